// File: rtl/deca_vip_irq_pkg.sv
// Shared constants for the deca_vip interrupt aggregator: register word
// addresses, ACTIVE register layout and interrupt ID width.
package deca_vip_irq_pkg;

   localparam logic [2:0] IRQ_PENDING = 3'd0;
   localparam logic [2:0] IRQ_ENABLE  = 3'd1;
   localparam logic [2:0] IRQ_MODE    = 3'd2;
   localparam logic [2:0] IRQ_ACTIVE  = 3'd3;
   localparam logic [2:0] IRQ_FORCE   = 3'd4;
   localparam logic [2:0] IRQ_CONTROL = 3'd5;

   localparam int ACTIVE_VALID_BIT = 15;
   localparam int IRQ_ID_W         = 4;

endpackage

// File: rtl/deca_vip_irq_sync.sv
// Single-bit synchroniser with a one-flop delayed copy used for rising-edge
// detection of an asynchronous interrupt line.
module deca_vip_irq_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic irq_in,
   output logic sync_o,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   dly_d;
   logic                   dly_q;

   // Shift chain next-state and delayed copy of the synchronised level.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], irq_in};
      dly_d  = sync_q[SYNC_STAGES-1];
   end

   // Synchroniser and delay flops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         dly_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         dly_q  <= dly_d;
      end
   end

   assign sync_o = sync_q[SYNC_STAGES-1];
   assign rise_o = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/deca_vip_irq_ctrl.sv
// Avalon-MM interrupt aggregator: per-source capture, masking, forcing and a
// fixed-priority (lowest index wins) registered interrupt output and ID.
module deca_vip_irq_ctrl
   import deca_vip_irq_pkg::*;
#(
   parameter int NUM_IRQ     = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                chipselect,
   input  logic [2:0]          address,
   input  logic                write_n,
   input  logic [15:0]         writedata,
   output logic [15:0]         readdata,
   input  logic [NUM_IRQ-1:0]  irq_in,
   output logic                irq_out,
   output logic [IRQ_ID_W-1:0] irq_id
);

   logic [NUM_IRQ-1:0]  sync_s;
   logic [NUM_IRQ-1:0]  rise_s;
   logic [NUM_IRQ-1:0]  wdata_s;
   logic [NUM_IRQ-1:0]  masked_s;
   logic                wr_s;
   logic                wr_pending_s;
   logic                wr_enable_s;
   logic                wr_mode_s;
   logic                wr_force_s;
   logic                wr_control_s;
   logic                active_valid_s;
   logic [IRQ_ID_W-1:0] active_id_s;
   logic [15:0]         active_word_s;
   logic                unused_s;

   logic [NUM_IRQ-1:0]  pending_d, pending_q;
   logic [NUM_IRQ-1:0]  enable_d,  enable_q;
   logic [NUM_IRQ-1:0]  mode_d,    mode_q;
   logic                control_d, control_q;
   logic [15:0]         readdata_d, readdata_q;
   logic                irq_out_d, irq_out_q;
   logic [IRQ_ID_W-1:0] irq_id_d,  irq_id_q;

   function automatic logic [15:0] zext(input logic [NUM_IRQ-1:0] v);
      logic [15:0] r;
      r = 16'h0000;
      r[NUM_IRQ-1:0] = v;
      return r;
   endfunction

   for (genvar g = 0; g < NUM_IRQ; g++) begin : g_src
      deca_vip_irq_sync #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
         .clk     (clk),
         .reset_n (reset_n),
         .irq_in  (irq_in[g]),
         .sync_o  (sync_s[g]),
         .rise_o  (rise_s[g])
      );
   end

   assign wr_s         = chipselect & ~write_n;
   assign wr_pending_s = wr_s & (address == IRQ_PENDING);
   assign wr_enable_s  = wr_s & (address == IRQ_ENABLE);
   assign wr_mode_s    = wr_s & (address == IRQ_MODE);
   assign wr_force_s   = wr_s & (address == IRQ_FORCE);
   assign wr_control_s = wr_s & (address == IRQ_CONTROL);
   assign wdata_s      = writedata[NUM_IRQ-1:0];
   assign unused_s     = ^writedata;

   // Register next-state; edge-mode set beats a same-cycle write-1 clear.
   always_comb begin
      enable_d  = wr_enable_s  ? wdata_s      : enable_q;
      mode_d    = wr_mode_s    ? wdata_s      : mode_q;
      control_d = wr_control_s ? writedata[0] : control_q;
      pending_d = pending_q;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (wr_mode_s && (wdata_s[i] != mode_q[i])) begin
            pending_d[i] = 1'b0;
         end else if (mode_q[i]) begin
            pending_d[i] = rise_s[i] | (wr_force_s & wdata_s[i])
                         | (pending_q[i] & ~(wr_pending_s & wdata_s[i]));
         end else begin
            pending_d[i] = sync_s[i];
         end
      end
   end

   // Fixed-priority encoder, read mux and output next-state.
   always_comb begin
      masked_s       = pending_q & enable_q;
      active_valid_s = 1'b0;
      active_id_s    = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         active_id_s    = masked_s[i] ? IRQ_ID_W'(i) : active_id_s;
         active_valid_s = active_valid_s | masked_s[i];
      end
      active_word_s = 16'h0000;
      active_word_s[ACTIVE_VALID_BIT]  = active_valid_s;
      active_word_s[IRQ_ID_W-1:0]      = active_id_s;

      case (address)
         IRQ_PENDING: readdata_d = zext(pending_q);
         IRQ_ENABLE:  readdata_d = zext(enable_q);
         IRQ_MODE:    readdata_d = zext(mode_q);
         IRQ_ACTIVE:  readdata_d = active_word_s;
         IRQ_CONTROL: readdata_d = {15'h0000, control_q};
         default:     readdata_d = 16'h0000;
      endcase

      irq_out_d = control_q & (|masked_s);
      irq_id_d  = active_id_s;
   end

   // Register state and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending_q  <= '0;
         enable_q   <= '0;
         mode_q     <= '0;
         control_q  <= 1'b0;
         readdata_q <= 16'h0000;
         irq_out_q  <= 1'b0;
         irq_id_q   <= '0;
      end else begin
         pending_q  <= pending_d;
         enable_q   <= enable_d;
         mode_q     <= mode_d;
         control_q  <= control_d;
         readdata_q <= readdata_d;
         irq_out_q  <= irq_out_d;
         irq_id_q   <= irq_id_d;
      end
   end

   assign readdata = readdata_q;
   assign irq_out  = irq_out_q;
   assign irq_id   = irq_id_q;

endmodule

// File: tb/tb_deca_vip_irq_ctrl.sv
// Directed bench for deca_vip_irq_ctrl: expected values are queued when the
// stimulus is applied and popped when the corresponding output is sampled.
module tb_deca_vip_irq_ctrl;
   import deca_vip_irq_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        chipselect;
   logic [2:0]  address;
   logic        write_n;
   logic [15:0] writedata;
   logic [15:0] readdata;
   logic [7:0]  irq_in;
   logic        irq_out;
   logic [3:0]  irq_id;

   typedef struct {
      string       tag;
      logic [15:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   deca_vip_irq_ctrl #(
      .NUM_IRQ     (8),
      .SYNC_STAGES (2)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .chipselect (chipselect),
      .address    (address),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq_in     (irq_in),
      .irq_out    (irq_out),
      .irq_id     (irq_id)
   );

   task automatic push(input string tag, input logic [15:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb_q.push_back(e);
   endtask

   task automatic check(input logic [15:0] obs);
      exp_t e;
      n_tests++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $display("FAIL sb_empty observed=%h expected=<queued value>", obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic bus_read(input logic [2:0] a, input string tag, input logic [15:0] exp);
      push(tag, exp);
      chipselect = 1'b1;
      write_n    = 1'b1;
      address    = a;
      @(negedge clk);
      chipselect = 1'b0;
      check(readdata);
   endtask

   initial begin
      reset_n    = 1'b0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = 3'd0;
      writedata  = 16'h0000;
      irq_in     = 8'h00;
      push("rst_readdata", 16'h0000);
      push("rst_irq_out", 16'h0000);
      push("rst_irq_id", 16'h0000);
      step(2);
      check(readdata);
      check({15'h0000, irq_out});
      check({12'h000, irq_id});
      reset_n = 1'b1;
      step(1);

      // Level path on the timer source
      bus_write(IRQ_ENABLE, 16'h0001);
      bus_write(IRQ_CONTROL, 16'h0001);
      irq_in[0] = 1'b1;
      push("lvl_rise_out_e3", 16'h0000);
      push("lvl_rise_out_e4", 16'h0001);
      push("lvl_rise_id_e4", 16'h0000);
      step(3);
      check({15'h0000, irq_out});
      step(1);
      check({15'h0000, irq_out});
      check({12'h000, irq_id});
      bus_write(IRQ_PENDING, 16'h0001);
      bus_read(IRQ_PENDING, "lvl_w1c_ignored", 16'h0001);
      push("lvl_out_hold", 16'h0001);
      check({15'h0000, irq_out});
      irq_in[0] = 1'b0;
      push("lvl_fall_out_e3", 16'h0001);
      push("lvl_fall_out_e4", 16'h0000);
      step(3);
      check({15'h0000, irq_out});
      step(1);
      check({15'h0000, irq_out});

      // Edge capture and write-1 clear on source 2
      bus_write(IRQ_ENABLE, 16'h0004);
      bus_write(IRQ_MODE, 16'h0004);
      irq_in[2] = 1'b1;
      step(1);
      irq_in[2] = 1'b0;
      step(4);
      bus_read(IRQ_PENDING, "edge_pending", 16'h0004);
      bus_read(IRQ_ACTIVE, "edge_active", 16'h8002);
      push("edge_out", 16'h0001);
      push("edge_id", 16'h0002);
      check({15'h0000, irq_out});
      check({12'h000, irq_id});
      bus_write(IRQ_PENDING, 16'h0004);
      push("edge_out_at_clear", 16'h0001);
      check({15'h0000, irq_out});
      push("edge_out_after_clear", 16'h0000);
      step(1);
      check({15'h0000, irq_out});
      bus_read(IRQ_PENDING, "edge_pending_cleared", 16'h0000);

      // Priority and masking with sources 3 and 5
      bus_write(IRQ_MODE, 16'h002C);
      bus_write(IRQ_FORCE, 16'h0028);
      bus_write(IRQ_ENABLE, 16'h0028);
      push("prio_id_3", 16'h0003);
      step(1);
      check({12'h000, irq_id});
      bus_write(IRQ_ENABLE, 16'h0020);
      push("prio_id_5", 16'h0005);
      step(1);
      check({12'h000, irq_id});
      bus_write(IRQ_CONTROL, 16'h0000);
      push("gate_out_off", 16'h0000);
      step(1);
      check({15'h0000, irq_out});
      bus_read(IRQ_ACTIVE, "gate_active", 16'h8005);

      // Edge on source 1 coincident with its write-1 clear
      bus_write(IRQ_MODE, 16'h002E);
      irq_in[1] = 1'b1;
      step(2);
      bus_write(IRQ_PENDING, 16'h0002);
      bus_read(IRQ_PENDING, "set_beats_clear", 16'h002A);
      bus_write(IRQ_PENDING, 16'h0002);
      step(3);
      bus_read(IRQ_PENDING, "held_high_one_event", 16'h0028);
      irq_in[1] = 1'b0;

      // FORCE and mode change on source 4, plus register readback
      bus_write(IRQ_MODE, 16'h003E);
      bus_write(IRQ_FORCE, 16'h0010);
      bus_read(IRQ_PENDING, "force_set", 16'h0038);
      bus_write(IRQ_MODE, 16'h002E);
      bus_read(IRQ_PENDING, "mode_change_clr", 16'h0028);
      bus_read(IRQ_MODE, "mode_rb", 16'h002E);
      bus_read(IRQ_FORCE, "force_reads_0", 16'h0000);
      bus_read(3'd6, "addr6_reads_0", 16'h0000);
      bus_write(IRQ_ENABLE, 16'hFFFF);
      bus_read(IRQ_ENABLE, "enable_width", 16'h00FF);

      // Asynchronous reset while irq_out is high and a read is in flight
      bus_write(IRQ_ENABLE, 16'h0028);
      bus_write(IRQ_CONTROL, 16'h0001);
      push("pre_rst_out", 16'h0001);
      push("pre_rst_id", 16'h0003);
      push("pre_rst_readdata", 16'h0001);
      step(1);
      check({15'h0000, irq_out});
      check({12'h000, irq_id});
      check(readdata);
      chipselect = 1'b1;
      address    = IRQ_ENABLE;
      #2;
      reset_n = 1'b0;
      push("arst_out", 16'h0000);
      push("arst_id", 16'h0000);
      push("arst_readdata", 16'h0000);
      #1;
      check({15'h0000, irq_out});
      check({12'h000, irq_id});
      check(readdata);
      chipselect = 1'b0;
      step(2);
      reset_n = 1'b1;
      step(1);
      bus_read(IRQ_PENDING, "post_rst_pending", 16'h0000);
      bus_read(IRQ_ENABLE, "post_rst_enable", 16'h0000);
      bus_read(IRQ_MODE, "post_rst_mode", 16'h0000);
      bus_read(IRQ_CONTROL, "post_rst_control", 16'h0000);
      bus_read(IRQ_ACTIVE, "post_rst_active", 16'h0000);

      n_tests++;
      assert (sb_q.size() == 0) else begin
         n_fail++;
         $error("FAIL sb_drain observed=%0d expected=0", sb_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
